// File: rtl/ram128x16_seq.sv
// Access sequencer in front of the ram128x16 macro: turns single read/write requests and bulk
// fill/verify jobs into ordered adrs/_ce/_we/_oe strobes, and owns the tristate enable for dataIn.
module ram128x16_seq #(
   parameter int ADDR_W     = 7,
   parameter int DATA_W     = 16,
   parameter int STROBE_CYC = 1
) (
   input  logic              clk,
   input  logic              _rst,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] base,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rdata,
   output logic [7:0]        err_count,
   output logic [ADDR_W-1:0] first_err_adrs,
   output logic              err_flag,
   output logic [ADDR_W-1:0] adrs,
   output logic              _ce,
   output logic              _we,
   output logic              _oe,
   output logic [DATA_W-1:0] ram_din,
   output logic              ram_din_en,
   input  logic [DATA_W-1:0] ram_dout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_STROBE,
      S_HOLD,
      S_DONE
   } state_t;

   localparam logic [1:0]        M_WRITE     = 2'b00;
   localparam logic [1:0]        M_READ      = 2'b01;
   localparam logic [1:0]        M_FILL      = 2'b10;
   localparam logic [1:0]        M_VERIFY    = 2'b11;
   localparam int                CNT_W       = 4;
   localparam logic [CNT_W-1:0]  STROBE_LAST = CNT_W'(STROBE_CYC - 1);
   localparam logic [ADDR_W-1:0] ADDR_MAX    = '1;

   state_t            state;
   logic [1:0]        mode_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] base_q;
   logic [CNT_W-1:0]  strobe_cnt;

   logic              is_write;
   logic              last_addr;
   logic [ADDR_W-1:0] next_adrs;
   logic [DATA_W-1:0] expect_word;
   logic              mismatch;
   logic [7:0]        err_next;

   // Job decode and the verify comparison against the base+address pattern
   always_comb begin
      is_write    = (mode_q == M_WRITE) || (mode_q == M_FILL);
      last_addr   = !mode_q[1] || (adrs == ADDR_MAX);
      next_adrs   = adrs + ADDR_W'(1);
      expect_word = base_q + DATA_W'(adrs);
      mismatch    = (mode_q == M_VERIFY) && (ram_dout != expect_word);
      err_next    = err_count;
      if (mismatch && (err_count != 8'hFF)) begin
         err_next = err_count + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!_rst) begin
         state          <= S_IDLE;
         mode_q         <= M_WRITE;
         wdata_q        <= '0;
         base_q         <= '0;
         strobe_cnt     <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         rdata          <= '0;
         err_count      <= '0;
         first_err_adrs <= '0;
         err_flag       <= 1'b0;
         adrs           <= '0;
         _ce            <= 1'b1;
         _we            <= 1'b1;
         _oe            <= 1'b1;
         ram_din        <= '0;
         ram_din_en     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               _ce        <= 1'b1;
               _we        <= 1'b1;
               _oe        <= 1'b1;
               ram_din_en <= 1'b0;
               if (start) begin
                  mode_q         <= mode;
                  wdata_q        <= wdata;
                  base_q         <= base;
                  busy           <= 1'b1;
                  err_count      <= '0;
                  err_flag       <= 1'b0;
                  first_err_adrs <= '0;
                  _ce            <= 1'b0;
                  adrs           <= mode[1] ? '0 : addr_in;
                  case (mode)
                     M_WRITE: begin
                        ram_din    <= wdata;
                        ram_din_en <= 1'b1;
                     end
                     M_FILL: begin
                        ram_din    <= base;
                        ram_din_en <= 1'b1;
                     end
                     default: ram_din_en <= 1'b0;
                  endcase
                  state <= S_SETUP;
               end
            end

            S_SETUP: begin
               strobe_cnt <= STROBE_LAST;
               if (is_write) begin
                  _we <= 1'b0;
               end else begin
                  _oe <= 1'b0;
               end
               state <= S_STROBE;
            end

            // Read data is taken on the edge that closes the final strobe cycle
            S_STROBE: begin
               if (strobe_cnt != '0) begin
                  strobe_cnt <= strobe_cnt - CNT_W'(1);
               end else begin
                  _we <= 1'b1;
                  _oe <= 1'b1;
                  if (!is_write) begin
                     rdata     <= ram_dout;
                     err_count <= err_next;
                     err_flag  <= (err_next != 8'd0);
                     if (mismatch && (err_count == 8'd0)) begin
                        first_err_adrs <= adrs;
                     end
                  end
                  state <= S_HOLD;
               end
            end

            // Bulk jobs stop at the top address instead of wrapping
            S_HOLD: begin
               if (last_addr) begin
                  _ce        <= 1'b1;
                  ram_din_en <= 1'b0;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  state      <= S_DONE;
               end else begin
                  adrs    <= next_adrs;
                  ram_din <= base_q + DATA_W'(next_adrs);
                  state   <= S_SETUP;
               end
            end

            S_DONE: state <= S_IDLE;

            default: state <= S_IDLE;
         endcase
      end
   end

   // wdata_q is kept for single writes whose data is launched straight from the port
   logic unused_ok;
   assign unused_ok = ^{wdata_q, M_READ};

   // Strobe sanity: write and output-enable never overlap, and the bus is released while reading
   always @(posedge clk) begin
      if (_rst) begin
         assert (_we || _oe);
         assert (_oe || !ram_din_en);
      end
   end

endmodule
